// File: rtl/delta_liafn_decoder.sv
// Receiver for the delta-spike link: buffers signed delta events in a small FIFO and rebuilds
// the sender's membrane state by saturating accumulation, with a periodic leak while idle.
module delta_liafn_decoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LEAK_PERIOD = 16,
  parameter int unsigned LEAK_SHIFT  = 3,
  parameter logic [7:0]  INIT_STATE  = 8'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     evt_valid,
  input  logic [7:0]               evt_delta,
  output logic                     evt_ready,
  output logic [7:0]               recon_state,
  output logic                     upd_valid,
  output logic                     leak_pulse,
  output logic                     sat_flag,
  output logic [7:0]               evt_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    recon_q, recon_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic          leak_q, leak_d;
  logic          sat_q, sat_d;

  logic              full, empty, push, pop_en;
  logic [7:0]        pop_delta;
  logic signed [9:0] sum;
  logic [7:0]        leak_step;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign empty     = (level_q == '0);
  // Ready depends only on registered occupancy; held low while reset is asserted.
  assign evt_ready = ~reset & ~full;
  assign push      = evt_valid & evt_ready;
  assign pop_en    = ~empty;

  assign pop_delta = mem_q[rd_ptr_q];
  assign sum       = $signed({2'b00, recon_q}) + $signed({{2{pop_delta[7]}}, pop_delta});
  assign leak_step = recon_q >> LEAK_SHIFT;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop_en);
    recon_d  = recon_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    upd_d    = 1'b0;
    leak_d   = 1'b0;
    sat_d    = 1'b0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      // A pop always wins over a leak expiring in the same cycle.
      rd_ptr_d = rd_ptr_q + 1'b1;
      upd_d    = 1'b1;
      cnt_d    = cnt_q + 8'd1;
      idle_d   = '0;
      if (sum > 10'sd255) begin
        recon_d = 8'hff;
        sat_d   = 1'b1;
      end else if (sum < 10'sd0) begin
        recon_d = 8'h00;
        sat_d   = 1'b1;
      end else begin
        recon_d = sum[7:0];
      end
    end else if (empty) begin
      if (idle_q == IW'(LEAK_PERIOD - 1)) begin
        recon_d = recon_q - leak_step;
        leak_d  = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: push is blocked while reset is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= evt_delta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idle_q   <= '0;
      recon_q  <= INIT_STATE;
      cnt_q    <= 8'd0;
      upd_q    <= 1'b0;
      leak_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      idle_q   <= idle_d;
      recon_q  <= recon_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      leak_q   <= leak_d;
      sat_q    <= sat_d;
    end
  end

  assign recon_state = recon_q;
  assign upd_valid   = upd_q;
  assign leak_pulse  = leak_q;
  assign sat_flag    = sat_q;
  assign evt_count   = cnt_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_delta_liafn_decoder.sv
// Randomised and directed bench for delta_liafn_decoder against a queue-based reference model.
module tb_delta_liafn_decoder;

  localparam int DEPTH = 4;
  localparam int LP    = 16;
  localparam int LS    = 3;
  localparam logic [7:0] INIT = 8'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       evt_valid = 1'b0;
  logic [7:0] evt_delta = 8'd0;
  logic       evt_ready;
  logic [7:0] recon_state;
  logic       upd_valid;
  logic       leak_pulse;
  logic       sat_flag;
  logic [7:0] evt_count;
  logic [2:0] fifo_level;

  delta_liafn_decoder #(
    .DEPTH      (DEPTH),
    .LEAK_PERIOD(LP),
    .LEAK_SHIFT (LS),
    .INIT_STATE (INIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt_valid  (evt_valid),
    .evt_delta  (evt_delta),
    .evt_ready  (evt_ready),
    .recon_state(recon_state),
    .upd_valid  (upd_valid),
    .leak_pulse (leak_pulse),
    .sat_flag   (sat_flag),
    .evt_count  (evt_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending deltas, integer state, idle-cycle count.
  int mq[$];
  int m_state, m_cnt, m_idle, m_sum;
  bit m_upd, m_leak, m_sat, m_ok = 1'b0, forced = 1'b0;
  bit m_was_empty, m_push;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_state = int'(INIT);
      m_cnt = 0;
      m_idle = 0;
      m_upd = 0;
      m_leak = 0;
      m_sat = 0;
      m_ok = 1;
    end else if (m_ok) begin
      m_was_empty = (mq.size() == 0);
      m_push = evt_valid && (mq.size() < DEPTH);
      m_upd = 0;
      m_leak = 0;
      m_sat = 0;
      if (!forced && !m_was_empty) begin
        m_sum = m_state + mq.pop_front();
        if (m_sum > 255) begin m_state = 255; m_sat = 1; end
        else if (m_sum < 0) begin m_state = 0; m_sat = 1; end
        else m_state = m_sum;
        m_cnt = (m_cnt + 1) % 256;
        m_upd = 1;
        m_idle = 0;
      end else if (m_was_empty) begin
        if (m_idle == LP - 1) begin
          m_state = m_state - (m_state / (1 << LS));
          m_leak = 1;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      if (m_push) mq.push_back(int'($signed(evt_delta)));
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check_eq("recon", recon_state, m_state);
      check_eq("upd", upd_valid, m_upd);
      check_eq("leak", leak_pulse, m_leak);
      check_eq("sat", sat_flag, m_sat);
      check_eq("count", evt_count, m_cnt);
      check_eq("level", fifo_level, mq.size());
      check_eq("ready", evt_ready, (!reset && mq.size() < DEPTH) ? 1 : 0);
    end
  end

  task automatic step(input bit v, input int d, output bit xfer);
    evt_valid = v;
    evt_delta = 8'(d);
    @(negedge clk);
    xfer = evt_valid && evt_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit x;
    repeat (n) step(0, 0, x);
  endtask

  task automatic do_reset();
    bit x;
    reset = 1'b1;
    step(0, 0, x);
    reset = 1'b0;
  endtask

  task automatic wait_leak(input string tag, input int exp);
    bit x;
    int n = 0;
    do begin
      step(0, 0, x);
      n++;
    end while (!leak_pulse && n < 40);
    check_eq({tag, "_period"}, n, LP);
    check_eq({tag, "_value"}, recon_state, exp);
  endtask

  initial begin
    bit x;
    bit v;
    int d;
    int n;

    // Reset values
    reset = 1'b1;
    step(0, 0, x);
    step(0, 0, x);
    check_eq("rst_recon", recon_state, INIT);
    check_eq("rst_upd", upd_valid, 0);
    check_eq("rst_count", evt_count, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ready", evt_ready, 0);
    reset = 1'b0;

    // Single event, two-cycle latency
    step(1, 12, x);
    check_eq("t1_upd_early", upd_valid, 0);
    step(0, 0, x);
    check_eq("t1_recon", recon_state, 12);
    check_eq("t1_upd", upd_valid, 1);
    check_eq("t1_count", evt_count, 1);
    check_eq("t1_sat", sat_flag, 0);

    // Back-to-back burst
    do_reset();
    step(1, 10, x);
    step(1, 20, x);
    check_eq("t2_r0", recon_state, 10);
    step(1, -5, x);
    check_eq("t2_r1", recon_state, 30);
    check_eq("t2_level", fifo_level, 1);
    check_eq("t2_ready", evt_ready, 1);
    step(0, 0, x);
    check_eq("t2_r2", recon_state, 25);

    // Saturation high and low
    do_reset();
    step(1, 127, x);
    step(1, 123, x);
    step(1, 20, x);
    step(0, 0, x);
    check_eq("t3_hi", recon_state, 255);
    check_eq("t3_hi_sat", sat_flag, 1);
    step(1, -128, x);
    step(1, -27, x);
    step(1, -128, x);
    check_eq("t3_mid", recon_state, 100);
    step(0, 0, x);
    check_eq("t3_lo", recon_state, 0);
    check_eq("t3_lo_sat", sat_flag, 1);

    // Leak chain and suppression by a pop on the expiry cycle
    do_reset();
    step(1, 80, x);
    step(0, 0, x);
    check_eq("t4_start", recon_state, 80);
    wait_leak("t4_l1", 70);
    wait_leak("t4_l2", 62);
    wait_leak("t4_l3", 55);
    idle(LP - 2);
    step(1, 0, x);
    step(0, 0, x);
    check_eq("t4_sup_leak", leak_pulse, 0);
    check_eq("t4_sup_upd", upd_valid, 1);
    check_eq("t4_sup_recon", recon_state, 55);
    wait_leak("t4_l4", 49);

    // Backpressure: drain paused, FIFO fills, fifth event held
    do_reset();
    force dut.pop_en = 1'b0;
    forced = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, 5 * i, x);
    check_eq("t5_level_full", fifo_level, 4);
    check_eq("t5_ready_low", evt_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 25, x);
      check_eq("t5_no_xfer", x, 0);
    end
    check_eq("t5_level_hold", fifo_level, 4);
    release dut.pop_en;
    forced = 1'b0;
    n = 0;
    do begin
      step(1, 25, x);
      n++;
    end while (!x && n < 6);
    check_eq("t5_held_xfer", x, 1);
    idle(4);
    check_eq("t5_count", evt_count, 5);
    check_eq("t5_recon", recon_state, 75);

    // Reset mid-burst flushes buffered events
    do_reset();
    force dut.pop_en = 1'b0;
    forced = 1'b1;
    step(1, 1, x);
    step(1, 2, x);
    step(1, 3, x);
    check_eq("t6_buffered", fifo_level, 3);
    reset = 1'b1;
    release dut.pop_en;
    forced = 1'b0;
    step(1, 7, x);
    reset = 1'b0;
    check_eq("t6_recon", recon_state, INIT);
    check_eq("t6_level", fifo_level, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, x);
      check_eq("t6_no_upd", upd_valid, 0);
    end

    // Event counter wrap
    do_reset();
    repeat (255) step(1, 0, x);
    idle(2);
    check_eq("t6_cnt255", evt_count, 255);
    step(1, 0, x);
    idle(2);
    check_eq("t6_cnt_wrap", evt_count, 0);

    // Random traffic with occasional drain pauses
    do_reset();
    v = 0;
    d = 0;
    x = 0;
    for (int i = 0; i < 600; i++) begin
      if (!v || x) begin
        v = ($urandom_range(0, 3) != 0);
        d = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 19) == 0) begin
        if (forced) begin
          release dut.pop_en;
          forced = 1'b0;
        end else begin
          force dut.pop_en = 1'b0;
          forced = 1'b1;
        end
      end
      if (i % 150 == 149) begin
        if (forced) begin
          release dut.pop_en;
          forced = 1'b0;
        end
        idle(40);
        v = 0;
      end
      step(v, d, x);
    end
    if (forced) begin
      release dut.pop_en;
      forced = 1'b0;
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=%0t exp=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
